// File: rtl/clk_tick_gen.sv
// Multi-channel programmable tick / clock-enable generator.
// Each channel divides clk_in by a runtime period N and emits a tick and a square wave.
module clk_tick_gen #(
    parameter int                          NUM_CH   = 2,
    parameter int                          CNT_W    = 27,
    parameter int                          CH_IDX_W = 4,
    parameter logic [NUM_CH*CNT_W-1:0]     DIV_INIT = {27'd100000000, 27'd100000}
) (
    input  logic                clk_in,
    input  logic                rst_n,
    input  logic [NUM_CH-1:0]   ch_en,
    input  logic                sync_clr,
    input  logic                wr_en,
    input  logic [CH_IDX_W-1:0] wr_ch,
    input  logic [CNT_W-1:0]    wr_div,
    output logic [NUM_CH-1:0]   tick_o,
    output logic [NUM_CH-1:0]   sq_o,
    output logic [NUM_CH-1:0]   pend_o
);

    // Periods below 2 cannot produce a tick and a square wave, so they are raised to 2.
    function automatic logic [CNT_W-1:0] clamp(input logic [CNT_W-1:0] x);
        return (x < CNT_W'(2)) ? CNT_W'(2) : x;
    endfunction

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] div_q, div_d;
        logic [CNT_W-1:0] pdiv_q, pdiv_d;
        logic             pend_q, pend_d;
        logic             tick_q, tick_d;
        logic             sq_q, sq_d;
        logic             wr_hit;
        logic             term;

        assign wr_hit = wr_en && (wr_ch == CH_IDX_W'(i));
        assign term   = (cnt_q == div_q - CNT_W'(1));

        always_comb begin
            cnt_d  = cnt_q;
            div_d  = div_q;
            pdiv_d = pdiv_q;
            pend_d = pend_q;
            tick_d = 1'b0;
            sq_d   = 1'b0;
            if (sync_clr) begin
                cnt_d = '0;
                if (pend_q) begin
                    div_d  = pdiv_q;
                    pend_d = 1'b0;
                end
                sq_d = ch_en[i];
            end else if (!ch_en[i]) begin
                cnt_d = '0;
            end else begin
                if (term) begin
                    cnt_d  = '0;
                    tick_d = 1'b1;
                    if (pend_q) begin
                        div_d  = pdiv_q;
                        pend_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                sq_d = (cnt_d < (div_d >> 1));
            end
            // A write lands after any pending value has been consumed this cycle.
            if (wr_hit) begin
                if (ch_en[i]) begin
                    pdiv_d = clamp(wr_div);
                    pend_d = 1'b1;
                end else begin
                    div_d  = clamp(wr_div);
                    pend_d = 1'b0;
                end
            end
        end

        always_ff @(posedge clk_in or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q  <= '0;
                div_q  <= clamp(DIV_INIT[i*CNT_W +: CNT_W]);
                pdiv_q <= clamp(DIV_INIT[i*CNT_W +: CNT_W]);
                pend_q <= 1'b0;
                tick_q <= 1'b0;
                sq_q   <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                div_q  <= div_d;
                pdiv_q <= pdiv_d;
                pend_q <= pend_d;
                tick_q <= tick_d;
                sq_q   <= sq_d;
            end
        end

        assign tick_o[i] = tick_q;
        assign sq_o[i]   = sq_q;
        assign pend_o[i] = pend_q;
    end

endmodule

// File: tb/tb_clk_tick_gen.sv
// Scoreboard bench for clk_tick_gen: per-edge expected {tick,sq,pend} vectors.
// Two channels, 8-bit counters, reset divisors ch0=4, ch1=1 (clamped to 2).
module tb_clk_tick_gen;
    localparam int NCH = 2;
    localparam int CW  = 8;
    localparam int IW  = 4;

    logic           clk_in = 1'b0;
    logic           rst_n;
    logic [NCH-1:0] ch_en;
    logic           sync_clr;
    logic           wr_en;
    logic [IW-1:0]  wr_ch;
    logic [CW-1:0]  wr_div;
    logic [NCH-1:0] tick_o;
    logic [NCH-1:0] sq_o;
    logic [NCH-1:0] pend_o;

    logic [5:0] exp_q[$];
    int         tag_q[$];
    int         checks = 0;
    int         errors = 0;
    int         step   = 0;

    clk_tick_gen #(
        .NUM_CH   (NCH),
        .CNT_W    (CW),
        .CH_IDX_W (IW),
        .DIV_INIT ({8'd1, 8'd4})
    ) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .ch_en    (ch_en),
        .sync_clr (sync_clr),
        .wr_en    (wr_en),
        .wr_ch    (wr_ch),
        .wr_div   (wr_div),
        .tick_o   (tick_o),
        .sq_o     (sq_o),
        .pend_o   (pend_o)
    );

    always #5 clk_in = ~clk_in;

    // Push the outputs expected after the next rising edge, then move to the next falling edge.
    task automatic cyc(input logic [1:0] t, input logic [1:0] s, input logic [1:0] p);
        exp_q.push_back({t, s, p});
        tag_q.push_back(step);
        step++;
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic wr(input int ch, input int d);
        wr_en  = 1'b1;
        wr_ch  = IW'(ch);
        wr_div = CW'(d);
    endtask

    initial begin : monitor
        logic [5:0] e;
        int         tg;
        forever begin
            @(posedge clk_in);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                tg = tag_q.pop_front();
                checks++;
                if ({tick_o, sq_o, pend_o} !== e) begin
                    errors++;
                    $display("FAIL step%0d: got tick=%b sq=%b pend=%b, expected tick=%b sq=%b pend=%b",
                             tg, tick_o, sq_o, pend_o, e[5:4], e[3:2], e[1:0]);
                end
            end
        end
    end

    initial begin : stim
        rst_n    = 1'b0;
        ch_en    = '0;
        sync_clr = 1'b0;
        wr_en    = 1'b0;
        wr_ch    = '0;
        wr_div   = '0;
        @(negedge clk_in);
        cyc(2'b00, 2'b00, 2'b00);
        cyc(2'b00, 2'b00, 2'b00);
        rst_n = 1'b1;
        cyc(2'b00, 2'b00, 2'b00);

        // ch0 at N=4: ticks on edges 4, 8, 12
        ch_en = 2'b01;
        cyc(2'b00, 2'b01, 2'b00);
        cyc(2'b00, 2'b00, 2'b00);
        cyc(2'b00, 2'b00, 2'b00);
        for (int k = 0; k < 2; k++) begin
            cyc(2'b01, 2'b01, 2'b00);
            cyc(2'b00, 2'b01, 2'b00);
            cyc(2'b00, 2'b00, 2'b00);
            cyc(2'b00, 2'b00, 2'b00);
        end
        cyc(2'b01, 2'b01, 2'b00);

        // mid-period write of 6: pending until the next terminal count
        wr(0, 6);
        cyc(2'b00, 2'b01, 2'b01);
        wr_en = 1'b0;
        cyc(2'b00, 2'b00, 2'b01);
        cyc(2'b00, 2'b00, 2'b01);
        for (int k = 0; k < 2; k++) begin
            cyc(2'b01, 2'b01, 2'b00);
            cyc(2'b00, 2'b01, 2'b00);
            cyc(2'b00, 2'b01, 2'b00);
            cyc(2'b00, 2'b00, 2'b00);
            cyc(2'b00, 2'b00, 2'b00);
            cyc(2'b00, 2'b00, 2'b00);
        end
        cyc(2'b01, 2'b01, 2'b00);

        // divisor 0 and 1 on disabled ch1 clamp to 2
        ch_en = 2'b00;
        wr(1, 5);
        cyc(2'b00, 2'b00, 2'b00);
        wr(1, 0);
        cyc(2'b00, 2'b00, 2'b00);
        wr_en = 1'b0;
        ch_en = 2'b10;
        for (int k = 0; k < 2; k++) begin
            cyc(2'b00, 2'b00, 2'b00);
            cyc(2'b10, 2'b10, 2'b00);
        end
        ch_en = 2'b00;
        wr(1, 9);
        cyc(2'b00, 2'b00, 2'b00);
        wr(1, 1);
        cyc(2'b00, 2'b00, 2'b00);
        wr_en = 1'b0;
        ch_en = 2'b10;
        for (int k = 0; k < 2; k++) begin
            cyc(2'b00, 2'b00, 2'b00);
            cyc(2'b10, 2'b10, 2'b00);
        end

        // ch0 N=5, ch1 N=3, phase-aligned by sync_clr
        ch_en = 2'b00;
        wr(0, 5);
        cyc(2'b00, 2'b00, 2'b00);
        wr(1, 3);
        cyc(2'b00, 2'b00, 2'b00);
        wr_en = 1'b0;
        ch_en = 2'b11;
        cyc(2'b00, 2'b01, 2'b00);
        cyc(2'b00, 2'b00, 2'b00);
        sync_clr = 1'b1;
        cyc(2'b00, 2'b11, 2'b00);
        sync_clr = 1'b0;
        cyc(2'b00, 2'b01, 2'b00);
        cyc(2'b00, 2'b00, 2'b00);
        cyc(2'b10, 2'b10, 2'b00);
        cyc(2'b00, 2'b00, 2'b00);
        cyc(2'b01, 2'b01, 2'b00);
        cyc(2'b10, 2'b11, 2'b00);

        // write 10 on the terminal cycle with 8 already pending
        ch_en = 2'b01;
        wr(0, 8);
        cyc(2'b00, 2'b00, 2'b01);
        wr_en = 1'b0;
        cyc(2'b00, 2'b00, 2'b01);
        cyc(2'b00, 2'b00, 2'b01);
        wr(0, 10);
        cyc(2'b01, 2'b01, 2'b01);
        wr_en = 1'b0;
        cyc(2'b00, 2'b01, 2'b01);
        wr(3, 20);
        cyc(2'b00, 2'b01, 2'b01);
        wr_en = 1'b0;
        cyc(2'b00, 2'b01, 2'b01);
        for (int k = 0; k < 4; k++) cyc(2'b00, 2'b00, 2'b01);
        cyc(2'b01, 2'b01, 2'b00);
        for (int k = 0; k < 4; k++) cyc(2'b00, 2'b01, 2'b00);
        for (int k = 0; k < 5; k++) cyc(2'b00, 2'b00, 2'b00);
        cyc(2'b01, 2'b01, 2'b00);

        // ch1 still at N=3: the out-of-range write touched nothing
        ch_en = 2'b10;
        for (int k = 0; k < 2; k++) begin
            cyc(2'b00, 2'b00, 2'b00);
            cyc(2'b00, 2'b00, 2'b00);
            cyc(2'b10, 2'b10, 2'b00);
        end

        // reset mid-period between edges, then restart from reset divisors
        ch_en = 2'b11;
        wr(0, 7);
        cyc(2'b00, 2'b01, 2'b01);
        wr_en = 1'b0;
        cyc(2'b00, 2'b01, 2'b01);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({tick_o, sq_o, pend_o} !== 6'b0) begin
            errors++;
            $display("FAIL async_reset: got tick=%b sq=%b pend=%b, expected all zero",
                     tick_o, sq_o, pend_o);
        end
        cyc(2'b00, 2'b00, 2'b00);
        #3;
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            cyc(2'b00, 2'b01, 2'b00);
            cyc(2'b10, 2'b10, 2'b00);
            cyc(2'b00, 2'b00, 2'b00);
            cyc(2'b11, 2'b11, 2'b00);
        end

        repeat (3) @(negedge clk_in);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
